// File: rtl/mk8_onchip_ram_pipe_if.sv
// Avalon-MM slave bus bundle for the Mk8 on-chip RAM.
// The master drives requests; the slave returns read data and flow control.
interface mk8_onchip_ram_pipe_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 13
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                chipselect;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (
      output address, byteenable, chipselect, read, write, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, byteenable, chipselect, read, write, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/mk8_onchip_ram_pipe.sv
// Parametrised on-chip RAM for Mk8 program/data memory: Avalon-MM slave with
// 1- or 2-cycle read latency, write freeze and a hardware clear engine.
module mk8_onchip_ram_pipe #(
   parameter int unsigned       DATA_W         = 32,
   parameter int unsigned       ADDR_W         = 13,
   parameter int unsigned       READ_LATENCY   = 1,
   parameter int unsigned       CLEAR_ON_RESET = 1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   mk8_onchip_ram_pipe_if.slave bus,
   input  logic                 clken,
   input  logic                 reset_req,
   input  logic                 freeze,
   input  logic                 clear_req,
   output logic                 clear_busy
);

   localparam int unsigned NumLanes = DATA_W / 8;
   localparam int unsigned Depth    = 2 ** ADDR_W;

   typedef enum logic [0:0] {StReady, StClear} state_e;

   localparam state_e ResetState = (CLEAR_ON_RESET != 0) ? StClear : StReady;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;

   logic en;
   logic in_clear;
   logic accept;
   logic wr_acc;
   logic rd_acc;

   logic [DATA_W-1:0] mem_q [Depth];
   logic [DATA_W-1:0] rd_word;

   logic              out_load;
   logic [DATA_W-1:0] out_data;
   logic              valid_q;
   logic [DATA_W-1:0] readdata_q;

   assign en       = clken & ~reset_req;
   assign in_clear = (state_q == StClear);

   assign bus.waitrequest = ~en | in_clear;
   assign accept          = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
   assign wr_acc          = accept & bus.write;
   assign rd_acc          = accept & bus.read & ~bus.write;

   // Held low while reset is asserted even though the engine is armed.
   assign clear_busy = in_clear & reset_n;

   always_comb begin
      state_d      = state_q;
      clear_addr_d = clear_addr_q;
      if (en) begin
         unique case (state_q)
            StReady: begin
               if (clear_req) begin
                  state_d      = StClear;
                  clear_addr_d = '0;
               end
            end
            StClear: begin
               clear_addr_d = clear_addr_q + 1'b1;
               if (clear_addr_q == '1) begin
                  state_d = StReady;
               end
            end
            default: state_d = StReady;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ResetState;
         clear_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         clear_addr_q <= clear_addr_d;
      end
   end

   // Array has no reset; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (en && reset_n) begin
         if (in_clear) begin
            mem_q[clear_addr_q] <= CLEAR_VALUE;
         end else if (wr_acc && !freeze) begin
            for (int i = 0; i < NumLanes; i++) begin
               if (bus.byteenable[i]) begin
                  mem_q[bus.address][i*8 +: 8] <= bus.writedata[i*8 +: 8];
               end
            end
         end
      end
   end

   assign rd_word = mem_q[bus.address];

   if (READ_LATENCY == 2) begin : g_lat2
      logic              s1_valid_q;
      logic [DATA_W-1:0] s1_data_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
         end else if (en) begin
            s1_valid_q <= rd_acc;
            if (rd_acc) begin
               s1_data_q <= rd_word;
            end
         end
      end

      assign out_load = s1_valid_q;
      assign out_data = s1_data_q;
   end else begin : g_lat1
      assign out_load = rd_acc;
      assign out_data = rd_word;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= 1'b0;
         readdata_q <= '0;
      end else if (en) begin
         valid_q <= out_load;
         if (out_load) begin
            readdata_q <= out_data;
         end
      end
   end

   // A return stalled by en=0 is presented on the next enabled cycle, so the
   // host sees exactly one strobe per accepted read.
   assign bus.readdatavalid = valid_q & en;
   assign bus.readdata      = readdata_q;

endmodule

// File: tb/tb_mk8_onchip_ram_pipe.sv
// Bench: two RAM instances (read latency 1 and 2) share one stimulus stream and
// are checked every cycle against a behavioural model, plus literal spot checks.
module tb_mk8_onchip_ram_pipe;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;
   localparam int unsigned NW = 16;
   localparam logic [31:0] CV = 32'hDEADBEEF;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clken = 1'b1;
   logic          reset_req = 1'b0;
   logic          freeze = 1'b0;
   logic          clear_req = 1'b0;
   logic [AW-1:0] address = '0;
   logic [3:0]    byteenable = '0;
   logic          chipselect = 1'b0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [31:0]   writedata = '0;

   logic [1:0]  clear_busy;
   logic [1:0]  rdv;
   logic [1:0]  wreq;
   logic [31:0] rdata [2];

   int tests = 0;
   int fails = 0;
   int rv_cnt [2] = '{0, 0};

   always #5 clk = ~clk;

   mk8_onchip_ram_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
   mk8_onchip_ram_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

   assign bus1.address    = address;
   assign bus1.byteenable = byteenable;
   assign bus1.chipselect = chipselect;
   assign bus1.read       = read;
   assign bus1.write      = write;
   assign bus1.writedata  = writedata;
   assign bus2.address    = address;
   assign bus2.byteenable = byteenable;
   assign bus2.chipselect = chipselect;
   assign bus2.read       = read;
   assign bus2.write      = write;
   assign bus2.writedata  = writedata;

   assign rdv      = {bus2.readdatavalid, bus1.readdatavalid};
   assign wreq     = {bus2.waitrequest, bus1.waitrequest};
   assign rdata[0] = bus1.readdata;
   assign rdata[1] = bus2.readdata;

   mk8_onchip_ram_pipe #(
      .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .clken(clken), .reset_req(reset_req),
      .freeze(freeze), .clear_req(clear_req), .clear_busy(clear_busy[0])
   );

   mk8_onchip_ram_pipe #(
      .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2), .clken(clken), .reset_req(reset_req),
      .freeze(freeze), .clear_req(clear_req), .clear_busy(clear_busy[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: memory array, clear countdown, and accepted reads keyed by the
   // index of the enabled edge that accepted them.
   logic [31:0] mem_m [NW];
   bit          busy_m = 1'b1;
   int          clr_ptr = 0;
   longint      en_cnt = 0;
   logic [31:0] pend_data [longint];
   logic [31:0] last_m [2] = '{32'h0, 32'h0};

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_m  = 1'b1;
         clr_ptr = 0;
         pend_data.delete();
         last_m[0] = '0;
         last_m[1] = '0;
      end else if (clken && !reset_req) begin
         en_cnt++;
         if (busy_m) begin
            mem_m[clr_ptr] = CV;
            clr_ptr++;
            if (clr_ptr == NW) busy_m = 1'b0;
         end else begin
            if (chipselect && write) begin
               if (!freeze) begin
                  for (int b = 0; b < 4; b++) begin
                     if (byteenable[b]) mem_m[address][b*8 +: 8] = writedata[b*8 +: 8];
                  end
               end
            end else if (chipselect && read) begin
               pend_data[en_cnt] = mem_m[address];
            end
            if (clear_req) begin
               busy_m  = 1'b1;
               clr_ptr = 0;
            end
         end
         // A read accepted at enabled edge k is loaded into the output at edge k+L-1.
         for (int i = 0; i < 2; i++) begin
            if (pend_data.exists(en_cnt - longint'(i))) last_m[i] = pend_data[en_cnt - longint'(i)];
         end
      end
   end

   bit en_now;
   bit exp_rdv;

   always @(negedge clk) begin
      en_now = clken && !reset_req;
      for (int i = 0; i < 2; i++) begin
         exp_rdv = reset_n && en_now && (pend_data.exists(en_cnt - longint'(i)) != 0);
         chk($sformatf("rdv[%0d]", i), 32'(rdv[i]), 32'(exp_rdv));
         chk($sformatf("readdata[%0d]", i), rdata[i], last_m[i]);
         chk($sformatf("waitrequest[%0d]", i), 32'(wreq[i]), 32'(!en_now || busy_m));
         chk($sformatf("clear_busy[%0d]", i), 32'(clear_busy[i]), 32'(busy_m && reset_n));
         if (rdv[i]) rv_cnt[i]++;
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   logic last_wreq_or;

   // One bus cycle starting at posedge+1; inputs return to idle afterwards.
   task automatic cyc_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      chipselect = 1'b1;
      read       = rd;
      write      = wr;
      address    = a;
      writedata  = d;
      byteenable = be;
      @(negedge clk);
      last_wreq_or = |wreq;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      clear_req  = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!wreq[0]) break;
         n++;
      end
   endtask

   // Count negedges from the accept edge to each return; the first `stall`
   // cycles are disabled via clken (or reset_req when use_rr is set).
   task automatic wait_ret(input int stall, input bit use_rr, output int lat0, output int lat1,
                           output logic [31:0] d0, output logic [31:0] d1);
      lat0 = -1;
      lat1 = -1;
      d0   = 'x;
      d1   = 'x;
      for (int k = 1; k <= 10; k++) begin
         clken     = !(k <= stall && !use_rr);
         reset_req = (k <= stall && use_rr);
         @(negedge clk);
         if (rdv[0] && lat0 < 0) begin lat0 = k; d0 = rdata[0]; end
         if (rdv[1] && lat1 < 0) begin lat1 = k; d1 = rdata[1]; end
         @(posedge clk);
         #1;
      end
      clken     = 1'b1;
      reset_req = 1'b0;
   endtask

   int          n;
   int          l0, l1;
   logic [31:0] d0, d1;
   int          snap [2];

   initial begin
      // Reset: waitrequest high, everything else low, then 16-cycle clear.
      repeat (3) sync();
      @(negedge clk);
      chk("reset_waitrequest", 32'(wreq), 32'h3);
      chk("reset_rdv", 32'(rdv), 32'h0);
      chk("reset_clear_busy", 32'(clear_busy), 32'h0);
      chk("reset_readdata", rdata[1], 32'h0);
      sync();
      reset_n = 1'b1;
      wait_ready(n);
      chk("clear_cycles", 32'(n), 32'd16);
      sync();
      for (int a = 0; a < 16; a++) cyc_op(1'b1, 1'b0, AW'(a), '0, '0);
      repeat (3) sync();

      // Byte-merged write then immediate read.
      cyc_op(1'b0, 1'b1, 4'd5, 32'h11223344, 4'hF);
      cyc_op(1'b0, 1'b1, 4'd5, 32'hAABBCCDD, 4'b0101);
      cyc_op(1'b1, 1'b0, 4'd5, '0, '0);
      wait_ret(0, 1'b0, l0, l1, d0, d1);
      chk("merge_lat1", 32'(l0), 32'd1);
      chk("merge_lat2", 32'(l1), 32'd2);
      chk("merge_data1", d0, 32'h11BB33DD);
      chk("merge_data2", d1, 32'h11BB33DD);
      chk("model_addr5", mem_m[5], 32'h11BB33DD);

      // Back-to-back reads.
      snap = rv_cnt;
      for (int a = 0; a < 4; a++) begin
         cyc_op(1'b1, 1'b0, AW'(a), '0, '0);
         chk("b2b_no_wait", 32'(last_wreq_or), 32'h0);
      end
      repeat (4) sync();
      chk("b2b_count1", 32'(rv_cnt[0] - snap[0]), 32'd4);
      chk("b2b_count2", 32'(rv_cnt[1] - snap[1]), 32'd4);

      // Frozen write is accepted but discarded.
      cyc_op(1'b0, 1'b1, 4'd7, 32'h0, 4'hF);
      freeze = 1'b1;
      cyc_op(1'b0, 1'b1, 4'd7, 32'hCAFEF00D, 4'hF);
      chk("freeze_accept", 32'(last_wreq_or), 32'h0);
      freeze = 1'b0;
      cyc_op(1'b1, 1'b0, 4'd7, '0, '0);
      wait_ret(0, 1'b0, l0, l1, d0, d1);
      chk("freeze_data1", d0, 32'h0);
      chk("freeze_data2", d1, 32'h0);

      // Stalls via clken and via reset_req.
      for (int m = 0; m < 2; m++) begin
         cyc_op(1'b1, 1'b0, 4'd3, '0, '0);
         wait_ret(3, m[0], l0, l1, d0, d1);
         chk($sformatf("stall%0d_lat1", m), 32'(l0), 32'd4);
         chk($sformatf("stall%0d_lat2", m), 32'(l1), 32'd5);
         chk($sformatf("stall%0d_data1", m), d0, CV);
         chk($sformatf("stall%0d_data2", m), d1, CV);
      end

      // Clear request with reads in flight, then reset mid-clear.
      snap = rv_cnt;
      cyc_op(1'b1, 1'b0, 4'd1, '0, '0);
      clear_req = 1'b1;
      cyc_op(1'b1, 1'b0, 4'd2, '0, '0);
      repeat (4) sync();
      chk("clear_drain1", 32'(rv_cnt[0] - snap[0]), 32'd2);
      chk("clear_drain2", 32'(rv_cnt[1] - snap[1]), 32'd2);
      chk("clear_busy_mid", 32'(clear_busy), 32'h3);
      reset_n = 1'b0;
      repeat (2) sync();
      reset_n = 1'b1;
      snap = rv_cnt;
      wait_ready(n);
      chk("reclear_cycles", 32'(n), 32'd16);
      chk("no_stray_rdv1", 32'(rv_cnt[0] - snap[0]), 32'd0);
      chk("no_stray_rdv2", 32'(rv_cnt[1] - snap[1]), 32'd0);
      sync();

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         chipselect = ($urandom_range(3) != 0);
         read       = $urandom_range(1)[0];
         write      = ($urandom_range(2) == 0);
         address    = AW'($urandom_range(NW - 1));
         writedata  = $urandom;
         byteenable = 4'($urandom_range(15));
         freeze     = ($urandom_range(7) == 0);
         clken      = ($urandom_range(7) != 0);
         reset_req  = ($urandom_range(15) == 0);
         clear_req  = ($urandom_range(99) == 0);
         sync();
      end
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      freeze     = 1'b0;
      clken      = 1'b1;
      reset_req  = 1'b0;
      clear_req  = 1'b0;
      repeat (20) sync();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
